// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the PWM fade sequencer: register map, FSM encoding
// and reset defaults.
package pwm_fade_pkg;

  localparam logic [4:0] ADDR_TGT_BASE = 5'h00;
  localparam logic [4:0] ADDR_STEP     = 5'h08;
  localparam logic [4:0] ADDR_PRE_LO   = 5'h09;
  localparam logic [4:0] ADDR_PRE_HI   = 5'h0A;
  localparam logic [4:0] ADDR_CTRL     = 5'h0B;
  localparam logic [4:0] ADDR_CUR_BASE = 5'h10;

  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE = 1'b0;
  localparam fsm_state_t ST_SCAN = 1'b1;

  localparam logic [7:0]  STEP_RST = 8'h01;
  localparam logic [15:0] PRE_RST  = 16'h0FFF;

endpackage

// File: rtl/pwm_fade_step.sv
// Saturating move of a duty value toward its target by at most 'step'.
// Never overshoots the target and never wraps.
module pwm_fade_step #(
  parameter int VAL_W = 8
) (
  input  logic [VAL_W-1:0] cur,
  input  logic [VAL_W-1:0] tgt,
  input  logic [VAL_W-1:0] step,
  output logic [VAL_W-1:0] nxt
);

  // Distance is taken in the direction of travel, so it is always non-negative
  // and cur +/- step is only used when it stays strictly short of tgt.
  always_comb begin
    nxt = cur;
    if (cur < tgt) begin
      if ((tgt - cur) <= step) nxt = tgt;
      else                     nxt = cur + step;
    end else if (cur > tgt) begin
      if ((cur - tgt) <= step) nxt = tgt;
      else                     nxt = cur - step;
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Fade controller for the 8-channel LED PWM bank. A prescaled tick launches a
// round-robin scan that moves each channel's current duty toward its target
// through one shared step unit.
module pwm_fade_sequencer
  import pwm_fade_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int VAL_W  = 8,
  parameter int PRE_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_wen,
  input  logic [4:0]              cfg_addr,
  input  logic [7:0]              cfg_wdata,
  output logic [7:0]              cfg_rdata,
  output logic [NUM_CH*VAL_W-1:0] pwm_val,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [VAL_W-1:0] tgt [NUM_CH];
  logic [VAL_W-1:0] cur [NUM_CH];
  logic [VAL_W-1:0] step;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] cnt;
  logic             enable;
  fsm_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             pending;
  logic             changed;
  logic             done_arm;

  logic             tick;
  logic             wr_tgt;
  logic             wr_ctrl;
  logic             snap;
  logic             stop;
  logic             last;
  logic             visit_chg;
  logic [VAL_W-1:0] nxt;

  // Shared step unit, steered to whichever channel the scan is visiting.
  pwm_fade_step #(.VAL_W(VAL_W)) u_step (
    .cur  (cur[idx]),
    .tgt  (tgt[idx]),
    .step (step),
    .nxt  (nxt)
  );

  // Write decode, tick and per-visit status.
  always_comb begin
    tick      = enable && (cnt == pre);
    wr_tgt    = cfg_wen && (cfg_addr[4:3] == ADDR_TGT_BASE[4:3]);
    wr_ctrl   = cfg_wen && (cfg_addr == ADDR_CTRL);
    snap      = wr_ctrl && cfg_wdata[1];
    stop      = (wr_ctrl && !cfg_wdata[0]) || !enable;
    last      = (idx == IDX_W'(NUM_CH - 1));
    visit_chg = (nxt != cur[idx]);
  end

  // Configuration registers written from the register interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      step   <= STEP_RST;
      pre    <= PRE_RST;
      enable <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) tgt[k] <= '0;
    end else if (cfg_wen) begin
      case (cfg_addr)
        ADDR_STEP:   step          <= cfg_wdata;
        ADDR_PRE_LO: pre[7:0]      <= cfg_wdata;
        ADDR_PRE_HI: pre[15:8]     <= cfg_wdata;
        ADDR_CTRL:   enable        <= cfg_wdata[0];
        default: if (wr_tgt) tgt[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
      endcase
    end
  end

  // Prescaler: free-runs 0..pre while enabled, parked at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst || !enable || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  // Scan FSM and current values. The snap assignment comes last so it wins
  // over a scan update to the same channel in the same cycle; it also drops
  // any accumulated change so a snap can never lead to a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pending  <= 1'b0;
      changed  <= 1'b0;
      done_arm <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) cur[k] <= '0;
    end else begin
      done_arm <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick && !(wr_ctrl && !cfg_wdata[0])) begin
            state   <= ST_SCAN;
            idx     <= '0;
            changed <= 1'b0;
          end
        end
        default: begin
          if (stop) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
          end else begin
            cur[idx] <= nxt;
            if (last) begin
              done_arm <= changed || visit_chg;
              changed  <= 1'b0;
              idx      <= '0;
              // A tick landing on the final visit counts as pending.
              if (pending || tick) pending <= 1'b0;
              else                 state   <= ST_IDLE;
            end else begin
              changed <= changed || visit_chg;
              idx     <= idx + 1'b1;
              if (tick) pending <= 1'b1;
            end
          end
        end
      endcase
      if (snap) begin
        for (int unsigned k = 0; k < NUM_CH; k++) cur[k] <= tgt[k];
        changed  <= 1'b0;
        done_arm <= 1'b0;
      end
    end
  end

  // Output bus, busy flag and done qualification.
  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      pwm_val[k*VAL_W +: VAL_W] = cur[k];
      busy = busy | (cur[k] != tgt[k]);
    end
    done = done_arm && !busy;
  end

  // Register read mux.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_STEP:   cfg_rdata = step;
      ADDR_PRE_LO: cfg_rdata = pre[7:0];
      ADDR_PRE_HI: cfg_rdata = pre[15:8];
      ADDR_CTRL:   cfg_rdata = {7'b0, enable};
      default: begin
        if (cfg_addr[4:3] == ADDR_TGT_BASE[4:3])      cfg_rdata = tgt[cfg_addr[IDX_W-1:0]];
        else if (cfg_addr[4:3] == ADDR_CUR_BASE[4:3]) cfg_rdata = cur[cfg_addr[IDX_W-1:0]];
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Directed bench for pwm_fade_sequencer.
module tb_pwm_fade_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wen;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [7:0]  cfg_rdata;
  logic [63:0] pwm_val;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int done_total = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_total++;

  pwm_fade_sequencer #(.NUM_CH(8), .VAL_W(8), .PRE_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_wen   (cfg_wen),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .pwm_val   (pwm_val),
    .busy      (busy),
    .done      (done)
  );

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_wen = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b1; cfg_wen = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd(5'h08, d); total++; if (d !== 8'h01) begin bad++; $display("FAIL reset_step got %h want 01", d); end
    rd(5'h09, d); total++; if (d !== 8'hFF) begin bad++; $display("FAIL reset_pre_lo got %h want ff", d); end
    rd(5'h0A, d); total++; if (d !== 8'h0F) begin bad++; $display("FAIL reset_pre_hi got %h want 0f", d); end
    rd(5'h0B, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_ctrl got %h want 00", d); end
    rd(5'h00, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_tgt0 got %h want 00", d); end
    total++; if (pwm_val !== 64'h0) begin bad++; $display("FAIL reset_pwm got %h want 0", pwm_val); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_fade_up;
    logic [7:0] seq [4];
    logic [7:0] prev0, prev7, c0, c7;
    int nchg, first0, first7, done_n, ndone;
    wr(5'h09, 8'h03); wr(5'h0A, 8'h00); wr(5'h08, 8'h40);
    wr(5'h00, 8'hFF); wr(5'h07, 8'h11);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL up_busy_pre got %b want 1", busy); end
    wr(5'h0B, 8'h01);
    prev0 = 8'h00; prev7 = 8'h00; nchg = 0; first0 = -1; first7 = -1; done_n = -1; ndone = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      c0 = pwm_val[7:0];
      c7 = pwm_val[63:56];
      if (c0 !== prev0) begin
        if (nchg < 4) seq[nchg] = c0;
        if (nchg == 0) first0 = n;
        nchg++;
        prev0 = c0;
      end
      if (c7 !== prev7) begin
        if (first7 < 0) first7 = n;
        prev7 = c7;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_n < 0) done_n = n;
      end
    end
    total++; if (first0 != 5) begin bad++; $display("FAIL up_ch0_latency got %0d want 5", first0); end
    total++; if (first7 != 12) begin bad++; $display("FAIL up_ch7_latency got %0d want 12", first7); end
    total++; if (pwm_val[63:56] !== 8'h11) begin bad++; $display("FAIL up_ch7_val got %h want 11", pwm_val[63:56]); end
    total++; if (nchg != 4) begin bad++; $display("FAIL up_nchg got %0d want 4", nchg); end
    total++; if ({seq[0], seq[1], seq[2], seq[3]} !== 32'h4080C0FF)
      begin bad++; $display("FAIL up_seq got %h %h %h %h want 40 80 c0 ff", seq[0], seq[1], seq[2], seq[3]); end
    total++; if (ndone != 1) begin bad++; $display("FAIL up_done_count got %0d want 1", ndone); end
    total++; if (done_n != 36) begin bad++; $display("FAIL up_done_cycle got %0d want 36", done_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL up_busy_end got %b want 0", busy); end
    wr(5'h0B, 8'h00);
  endtask

  task automatic test_fade_down;
    logic [7:0] seq [3];
    logic [7:0] d, prev3, c3;
    int nchg, first3, done_n, ndone, d0;
    wr(5'h03, 8'h50);
    d0 = done_total;
    wr(5'h0B, 8'h02);
    rd(5'h13, d); total++; if (d !== 8'h50) begin bad++; $display("FAIL snap_cur3 got %h want 50", d); end
    rd(5'h0B, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL snap_ctrl_read got %h want 00", d); end
    total++; if (pwm_val[7:0] !== 8'hFF) begin bad++; $display("FAIL snap_ch0 got %h want ff", pwm_val[7:0]); end
    repeat (3) @(negedge clk);
    total++; if (done_total != d0) begin bad++; $display("FAIL snap_no_done got %0d want %0d", done_total, d0); end
    wr(5'h03, 8'h05); wr(5'h08, 8'h20); wr(5'h0B, 8'h01);
    prev3 = 8'h50; nchg = 0; first3 = -1; done_n = -1; ndone = 0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      c3 = pwm_val[31:24];
      if (c3 !== prev3) begin
        if (nchg < 3) seq[nchg] = c3;
        if (nchg == 0) first3 = n;
        nchg++;
        prev3 = c3;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_n < 0) done_n = n;
      end
    end
    total++; if (first3 != 8) begin bad++; $display("FAIL down_ch3_latency got %0d want 8", first3); end
    total++; if (nchg != 3) begin bad++; $display("FAIL down_nchg got %0d want 3", nchg); end
    total++; if ({seq[0], seq[1], seq[2]} !== 24'h301005)
      begin bad++; $display("FAIL down_seq got %h %h %h want 30 10 05", seq[0], seq[1], seq[2]); end
    total++; if (ndone != 1) begin bad++; $display("FAIL down_done_count got %0d want 1", ndone); end
    total++; if (done_n != 28) begin bad++; $display("FAIL down_done_cycle got %0d want 28", done_n); end
    wr(5'h0B, 8'h00);
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    int upd;
    for (int k = 0; k < 8; k++) wr(5'(k), 8'h10);
    wr(5'h0B, 8'h02);
    for (int k = 0; k < 8; k++) wr(5'(k), 8'h20);
    wr(5'h08, 8'h01); wr(5'h09, 8'h00); wr(5'h0A, 8'h00);
    wr(5'h0B, 8'h01);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        upd = (n >= 2 + k) ? 1 + (n - 2 - k) / 8 : 0;
        exp[k*8 +: 8] = 8'(8'h10 + upd);
      end
      total++; if (pwm_val !== exp) begin bad++; $display("FAIL b2b_cycle%0d got %h want %h", n, pwm_val, exp); end
    end
    wr(5'h0B, 8'h00);
  endtask

  task automatic test_target_collision;
    logic [7:0] d;
    wr(5'h02, 8'h10); wr(5'h0B, 8'h02); wr(5'h02, 8'h20); wr(5'h0B, 8'h01);
    repeat (3) @(negedge clk);
    cfg_wen = 1'b1; cfg_addr = 5'h02; cfg_wdata = 8'h00;
    @(negedge clk);
    cfg_wen = 1'b0;
    total++; if (pwm_val[23:16] !== 8'h11) begin bad++; $display("FAIL coll_old_tgt got %h want 11", pwm_val[23:16]); end
    repeat (7) @(negedge clk);
    total++; if (pwm_val[23:16] !== 8'h11) begin bad++; $display("FAIL coll_hold got %h want 11", pwm_val[23:16]); end
    @(negedge clk);
    total++; if (pwm_val[23:16] !== 8'h10) begin bad++; $display("FAIL coll_new_tgt got %h want 10", pwm_val[23:16]); end
    rd(5'h02, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL coll_tgt_read got %h want 00", d); end
    wr(5'h0B, 8'h00);
  endtask

  task automatic test_disable_midscan;
    logic [7:0] d;
    int d0;
    for (int k = 0; k < 8; k++) wr(5'(k), 8'h40);
    wr(5'h0B, 8'h02);
    for (int k = 0; k < 8; k++) wr(5'(k), 8'h50);
    wr(5'h0B, 8'h01);
    repeat (5) @(negedge clk);
    cfg_wen = 1'b1; cfg_addr = 5'h0B; cfg_wdata = 8'h00;
    @(negedge clk);
    cfg_wen = 1'b0;
    total++; if (pwm_val !== 64'h40404040_41414141) begin bad++; $display("FAIL dis_partial got %h want 4040404041414141", pwm_val); end
    repeat (10) @(negedge clk);
    total++; if (pwm_val !== 64'h40404040_41414141) begin bad++; $display("FAIL dis_idle got %h want 4040404041414141", pwm_val); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL dis_busy got %b want 1", busy); end
    rd(5'h0B, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL dis_ctrl got %h want 00", d); end
    d0 = done_total;
    wr(5'h0B, 8'h02);
    repeat (3) @(negedge clk);
    total++; if (pwm_val !== {8{8'h50}}) begin bad++; $display("FAIL dis_snap got %h want 5050505050505050", pwm_val); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_snap_busy got %b want 0", busy); end
    total++; if (done_total != d0) begin bad++; $display("FAIL dis_snap_done got %0d want %0d", done_total, d0); end
    wr(5'h14, 8'hAA);
    rd(5'h14, d); total++; if (d !== 8'h50) begin bad++; $display("FAIL cur_ro got %h want 50", d); end
    rd(5'h0C, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped_0c got %h want 00", d); end
    rd(5'h1F, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL unmapped_1f got %h want 00", d); end
  endtask

  task automatic test_reset_midscan;
    logic [7:0] d;
    wr(5'h00, 8'h60); wr(5'h0B, 8'h01);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (pwm_val !== 64'h0) begin bad++; $display("FAIL rstmid_pwm got %h want 0", pwm_val); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    rd(5'h08, d); total++; if (d !== 8'h01) begin bad++; $display("FAIL rstmid_step got %h want 01", d); end
    rd(5'h09, d); total++; if (d !== 8'hFF) begin bad++; $display("FAIL rstmid_pre_lo got %h want ff", d); end
    rd(5'h00, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL rstmid_tgt0 got %h want 00", d); end
    rd(5'h0B, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL rstmid_ctrl got %h want 00", d); end
    repeat (5) @(negedge clk);
    total++; if (pwm_val !== 64'h0) begin bad++; $display("FAIL rstmid_hold got %h want 0", pwm_val); end
  endtask

  initial begin
    test_reset;
    test_fade_up;
    test_fade_down;
    test_back_to_back;
    test_target_collision;
    test_disable_midscan;
    test_reset_midscan;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
